// File: rtl/tetris_pkg.sv
// Shared playfield types and constants for the falling-block game.
// Colours, board dimensions and the stored cell layout.
package tetris_pkg;

   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;
   localparam int COLOR_W = 3;

   typedef enum logic [COLOR_W-1:0] {
      BLACK   = 3'd0,
      RED     = 3'd1,
      GREEN   = 3'd2,
      YELLOW  = 3'd3,
      BLUE    = 3'd4,
      MAGENTA = 3'd5,
      CYAN    = 3'd6,
      WHITE   = 3'd7
   } block_color;

   typedef struct packed {
      logic       occupied;
      block_color color;
   } board_cell_t;

   typedef logic [BOARD_H-1:0][BOARD_W-1:0] occ_map_t;

   function automatic logic cell_in_bounds(input logic [4:0] x,
                                           input logic [4:0] y);
      return (x < 5'(BOARD_W)) && (y < 5'(BOARD_H));
   endfunction

endpackage

// File: rtl/piece_collide.sv
// Four-cell collision check: any cell off the board or on an
// occupied square is a hit. Purely combinational.
module piece_collide
   import tetris_pkg::*;
(
   input  logic [19:0] xblock_i,
   input  logic [19:0] yblock_i,
   input  occ_map_t    occ_i,
   output logic [3:0]  oob_o,
   output logic        hit_o
);

   logic [4:0] x;
   logic [4:0] y;

   always_comb begin
      oob_o = '0;
      hit_o = 1'b0;
      x     = '0;
      y     = '0;
      for (int i = 0; i < 4; i++) begin
         x = xblock_i[5*i +: 5];
         y = yblock_i[5*i +: 5];
         if (!cell_in_bounds(x, y)) begin
            oob_o[i] = 1'b1;
            hit_o    = 1'b1;
         end else if (occ_i[y][x[3:0]]) begin
            hit_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/board_lock_clear.sv
// Playfield store: locks landed pieces, clears and compacts full rows,
// answers collision queries and serves cell colour to the renderer.
module board_lock_clear
   import tetris_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset,
   input  logic               lock,
   input  logic [19:0]        lock_xblock,
   input  logic [19:0]        lock_yblock,
   input  logic [COLOR_W-1:0] lock_color,
   input  logic [19:0]        query_xblock,
   input  logic [19:0]        query_yblock,
   output logic               query_hit,
   input  logic [4:0]         x_coord,
   input  logic [4:0]         y_coord,
   output logic               cell_occupied,
   output logic [COLOR_W-1:0] cell_color,
   output logic               busy,
   output logic               clear_done,
   output logic [2:0]         rows_cleared,
   output logic [15:0]        lines_total,
   output logic               game_over,
   output logic               lock_dropped
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   board_cell_t board_q [BOARD_H][BOARD_W];
   board_cell_t board_d [BOARD_H][BOARD_W];

   logic [1:0]  state_q, state_d;
   logic [4:0]  ptr_q, ptr_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  rows_q, rows_d;
   logic [15:0] lines_q, lines_d;
   logic        go_q, go_d;
   logic        drop_q, drop_d;

   occ_map_t    occ;
   logic        row_full;
   logic        q_hit;
   logic [3:0]  q_oob;
   logic [4:0]  lx, ly;
   logic [16:0] lines_sum;

   always_comb begin
      for (int r = 0; r < BOARD_H; r++)
         for (int c = 0; c < BOARD_W; c++)
            occ[r][c] = board_q[r][c].occupied;
   end

   assign row_full = &occ[ptr_q];

   piece_collide u_query (
      .xblock_i (query_xblock),
      .yblock_i (query_yblock),
      .occ_i    (occ),
      .oob_o    (q_oob),
      .hit_o    (q_hit)
   );

   assign busy      = (state_q == S_SCAN) || (state_q == S_DONE);
   assign query_hit = busy || q_hit;
   assign lines_sum = {1'b0, lines_q} + 17'(cnt_q);

   always_comb begin
      board_d = board_q;
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      rows_d  = rows_q;
      lines_d = lines_q;
      go_d    = go_q;
      drop_d  = drop_q;
      lx      = '0;
      ly      = '0;
      unique case (state_q)
         S_IDLE: begin
            if (lock) begin
               for (int i = 0; i < 4; i++) begin
                  lx = lock_xblock[5*i +: 5];
                  ly = lock_yblock[5*i +: 5];
                  if (!cell_in_bounds(lx, ly)) begin
                     go_d = 1'b1;
                  end else begin
                     if (board_q[ly][lx[3:0]].occupied)
                        go_d = 1'b1;
                     board_d[ly][lx[3:0]].occupied = 1'b1;
                     board_d[ly][lx[3:0]].color = block_color'(lock_color);
                  end
               end
               ptr_d   = 5'(BOARD_H - 1);
               cnt_d   = '0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            // A full row is rescanned after the shift since new data fell in.
            if (row_full) begin
               for (int r = 1; r < BOARD_H; r++)
                  if (5'(r) <= ptr_q)
                     board_d[r] = board_q[r-1];
               for (int c = 0; c < BOARD_W; c++)
                  board_d[0][c] = '0;
               cnt_d = cnt_q + 3'd1;
            end else if (ptr_q == '0) begin
               state_d = S_DONE;
            end else begin
               ptr_d = ptr_q - 5'd1;
            end
         end
         S_DONE: begin
            rows_d  = cnt_q;
            lines_d = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (lock && state_q != S_IDLE)
         drop_d = 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int r = 0; r < BOARD_H; r++)
            for (int c = 0; c < BOARD_W; c++)
               board_q[r][c] <= '0;
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         rows_q  <= '0;
         lines_q <= '0;
         go_q    <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         board_q <= board_d;
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         rows_q  <= rows_d;
         lines_q <= lines_d;
         go_q    <= go_d;
         drop_q  <= drop_d;
      end
   end

   assign clear_done   = (state_q == S_DONE);
   assign rows_cleared = clear_done ? cnt_q : rows_q;
   assign lines_total  = lines_q;
   assign game_over    = go_q;
   assign lock_dropped = drop_q;

   always_comb begin
      cell_occupied = 1'b0;
      cell_color    = '0;
      if (cell_in_bounds(x_coord, y_coord)) begin
         cell_occupied = board_q[y_coord][x_coord[3:0]].occupied;
         cell_color    = board_q[y_coord][x_coord[3:0]].color;
      end
   end

endmodule

// File: tb/tb_board_lock_clear.sv
// Directed bench for board_lock_clear: locks, row clears, queries,
// overlap/drop flags and reset during a sequence.
module tb_board_lock_clear;
   import tetris_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        lock = 1'b0;
   logic [19:0] lock_xblock = '0;
   logic [19:0] lock_yblock = '0;
   logic [2:0]  lock_color = '0;
   logic [19:0] query_xblock = '0;
   logic [19:0] query_yblock = '0;
   logic        query_hit;
   logic [4:0]  x_coord = '0;
   logic [4:0]  y_coord = '0;
   logic        cell_occupied;
   logic [2:0]  cell_color;
   logic        busy;
   logic        clear_done;
   logic [2:0]  rows_cleared;
   logic [15:0] lines_total;
   logic        game_over;
   logic        lock_dropped;

   int n_vec = 0;
   int n_bad = 0;

   board_lock_clear dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .lock         (lock),
      .lock_xblock  (lock_xblock),
      .lock_yblock  (lock_yblock),
      .lock_color   (lock_color),
      .query_xblock (query_xblock),
      .query_yblock (query_yblock),
      .query_hit    (query_hit),
      .x_coord      (x_coord),
      .y_coord      (y_coord),
      .cell_occupied(cell_occupied),
      .cell_color   (cell_color),
      .busy         (busy),
      .clear_done   (clear_done),
      .rows_cleared (rows_cleared),
      .lines_total  (lines_total),
      .game_over    (game_over),
      .lock_dropped (lock_dropped)
   );

   always #10 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] pk(input int a, input int b,
                                      input int c, input int d);
      return {5'(d), 5'(c), 5'(b), 5'(a)};
   endfunction

   // Returns {occupied, colour} of one cell.
   task automatic rd(input int x, input int y, output logic [3:0] v);
      x_coord = 5'(x);
      y_coord = 5'(y);
      #1;
      v = {cell_occupied, cell_color};
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      #1 Reset = 1'b0;
   endtask

   task automatic run_lock(input logic [19:0] xs, input logic [19:0] ys,
                           input logic [2:0] col, output int busy_n,
                           output int done_at, output int rc,
                           output logic occ_k);
      busy_n  = 0;
      done_at = -1;
      rc      = -1;
      @(negedge Clk);
      lock_xblock = xs;
      lock_yblock = ys;
      lock_color  = col;
      lock        = 1'b1;
      @(posedge Clk);
      #1;
      lock  = 1'b0;
      occ_k = cell_occupied;
      for (int i = 0; i < 200; i++) begin
         @(negedge Clk);
         if (!busy) break;
         busy_n++;
         if (clear_done) begin
            done_at = i;
            rc      = int'(rows_cleared);
         end
      end
   endtask

   initial begin
      int         bn, da, rc, cnt;
      logic       ok;
      logic [3:0] v;

      do_reset();
      @(negedge Clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", clear_done, 0);
      check_eq("rst_rows", rows_cleared, 0);
      check_eq("rst_lines", lines_total, 0);
      check_eq("rst_go", game_over, 0);
      check_eq("rst_drop", lock_dropped, 0);

      // T-piece
      x_coord = 5; y_coord = 0;
      run_lock(pk(4,5,5,6), pk(1,0,1,1), 3'(MAGENTA), bn, da, rc, ok);
      check_eq("t_vis_k", ok, 1);
      check_eq("t_busy", bn, 21);
      check_eq("t_done_at", da, 20);
      check_eq("t_rows", rc, 0);
      rd(4,1,v); check_eq("t_c41", v, 4'hD);
      rd(5,0,v); check_eq("t_c50", v, 4'hD);
      rd(5,1,v); check_eq("t_c51", v, 4'hD);
      rd(6,1,v); check_eq("t_c61", v, 4'hD);
      rd(4,0,v); check_eq("t_c40", v, 0);
      rd(10,0,v); check_eq("rd_oobx", v, 0);
      rd(31,31,v); check_eq("rd_oobxy", v, 0);

      query_xblock = pk(31,0,1,2); query_yblock = pk(5,5,5,5); #1;
      check_eq("q_x31", query_hit, 1);
      query_xblock = pk(0,1,2,3); query_yblock = pk(20,5,5,5); #1;
      check_eq("q_y20", query_hit, 1);
      query_xblock = pk(5,0,1,2); query_yblock = pk(0,10,10,10); #1;
      check_eq("q_occ", query_hit, 1);
      query_xblock = pk(0,1,2,3); query_yblock = pk(10,10,10,10); #1;
      check_eq("q_free", query_hit, 0);
      check_eq("t_go", game_over, 0);

      run_lock(pk(5,0,1,2), pk(0,10,10,10), 3'(CYAN), bn, da, rc, ok);
      check_eq("ovl_go", game_over, 1);
      rd(5,0,v); check_eq("ovl_c50", v, 4'hE);

      do_reset();
      run_lock(pk(10,0,1,2), pk(0,0,0,0), 3'(RED), bn, da, rc, ok);
      check_eq("oob_go", game_over, 1);
      rd(0,0,v); check_eq("oob_c00", v, 4'h9);

      // Single-row clear
      do_reset();
      run_lock(pk(0,1,2,3), pk(19,19,19,19), 3'(RED), bn, da, rc, ok);
      run_lock(pk(4,5,0,1), pk(19,19,18,18), 3'(GREEN), bn, da, rc, ok);
      run_lock(pk(6,7,8,9), pk(19,19,19,19), 3'(BLUE), bn, da, rc, ok);
      check_eq("r1_busy", bn, 22);
      check_eq("r1_done_at", da, 21);
      check_eq("r1_rows", rc, 1);
      check_eq("r1_hold", rows_cleared, 1);
      check_eq("r1_lines", lines_total, 1);
      rd(0,19,v); check_eq("r1_c0_19", v, 4'hA);
      rd(1,19,v); check_eq("r1_c1_19", v, 4'hA);
      rd(2,19,v); check_eq("r1_c2_19", v, 0);
      rd(0,18,v); check_eq("r1_c0_18", v, 0);
      check_eq("r1_go", game_over, 0);

      // Reset in the middle of a scan
      @(negedge Clk);
      lock_xblock = pk(4,5,5,6); lock_yblock = pk(1,0,1,1);
      lock_color = 3'(YELLOW); lock = 1'b1;
      @(posedge Clk);
      #1 lock = 1'b0;
      repeat (5) @(negedge Clk);
      check_eq("mid_busy", busy, 1);
      do_reset();
      @(negedge Clk);
      check_eq("mr_busy", busy, 0);
      check_eq("mr_rows", rows_cleared, 0);
      check_eq("mr_lines", lines_total, 0);
      rd(5,0,v); check_eq("mr_c50", v, 0);
      rd(0,19,v); check_eq("mr_c0_19", v, 0);

      // Four-row clear
      for (int r = 16; r < 20; r++) begin
         run_lock(pk(0,1,2,3), pk(r,r,r,r), 3'(RED), bn, da, rc, ok);
         run_lock(pk(4,5,6,7), pk(r,r,r,r), 3'(GREEN), bn, da, rc, ok);
      end
      run_lock(pk(8,8,8,8), pk(16,17,18,19), 3'(BLUE), bn, da, rc, ok);
      run_lock(pk(9,9,9,9), pk(16,17,18,19), 3'(CYAN), bn, da, rc, ok);
      check_eq("r4_busy", bn, 25);
      check_eq("r4_rows", rc, 4);
      check_eq("r4_lines", lines_total, 4);
      check_eq("r4_go", game_over, 0);
      cnt = 0;
      for (int y = 0; y < BOARD_H; y++)
         for (int x = 0; x < BOARD_W; x++) begin
            rd(x, y, v);
            if (v[3]) cnt++;
         end
      check_eq("r4_empty", cnt, 0);

      // Busy query and dropped lock
      do_reset();
      query_xblock = pk(0,1,2,3); query_yblock = pk(5,5,5,5);
      @(negedge Clk);
      lock_xblock = pk(0,1,2,3); lock_yblock = pk(10,10,10,10);
      lock_color = 3'(WHITE); lock = 1'b1;
      @(posedge Clk);
      #1 lock = 1'b0;
      repeat (3) @(negedge Clk);
      check_eq("q_busy", query_hit, 1);
      lock_xblock = pk(0,1,2,3); lock_yblock = pk(5,5,5,5);
      lock = 1'b1;
      @(posedge Clk);
      #1 lock = 1'b0;
      for (int i = 0; i < 100 && busy; i++) @(negedge Clk);
      check_eq("drp_idle", busy, 0);
      check_eq("drp_flag", lock_dropped, 1);
      check_eq("drp_go", game_over, 0);
      rd(0,5,v); check_eq("drp_c05", v, 0);
      rd(0,10,v); check_eq("drp_c010", v, 4'hF);
      #1 check_eq("q_idle", query_hit, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/board_lock_clear.md
# board_lock_clear

Playfield store for the falling-block game. It sits directly downstream of the active-piece controller, `block_logic`. When that controller raises `get_new_block`, this block writes the landed piece into a 10×20 board, then clears full rows and compacts the board. It also answers the controller's collision queries, which become `can_move`, and serves per-cell colour to the pixel renderer.

## Interface
- `BOARD_W`, 10: columns.
- `BOARD_H`, 20: rows; row 0 is the top.
- `COLOR_W`, 3: width of `block_color`.
- `Clk`  in  1: system clock, 50 MHz. One clock domain only.
- `Reset`  in  1: synchronous, active-high.
- `lock`  in  1: one-cycle pulse; connects to `get_new_block`.
- `lock_xblock`, `lock_yblock`  in  20 each: the piece to lock, as four packed 5-bit coordinates. Cell i is bits [5i+4:5i].
- `lock_color`  in  `COLOR_W`: colour of the piece being locked.
- `query_xblock`, `query_yblock`  in  20 each: candidate piece position for a collision check (same packing).
- `query_hit`  out  1: combinational collision result for the query.
- `x_coord`, `y_coord`  in  5 each: renderer read address.
- `cell_occupied`  out  1: combinational read of the addressed cell.
- `cell_color`  out  `COLOR_W`: combinational read of the addressed cell.
- `busy`  out  1: high while a lock or clear sequence is in progress.
- `clear_done`  out  1: one-cycle pulse at the end of every lock sequence.
- `rows_cleared`  out  3: rows removed by the last sequence, 0–4. Held until the next sequence.
- `lines_total`  out  16: running count of cleared rows. Saturates at 16'hFFFF.
- `game_over`  out  1: sticky.
- `lock_dropped`  out  1: sticky.

## Operation
- **Storage:** per cell, an occupied bit plus a `block_color` value. Reset empties every cell.
- **Reset values:** `busy`=0, `clear_done`=0, `rows_cleared`=0, `lines_total`=0, `game_over`=0, `lock_dropped`=0, FSM in IDLE.
- **FSM states:** IDLE, SCAN, DONE.
- **IDLE:**
  - On `lock`, at that same edge: write all four cells (occupied=1, colour=`lock_color`).
  - Set the row pointer to `BOARD_H-1` and the per-sequence count to 0, then go to SCAN.
  - Any cell with x≥`BOARD_W` or y≥`BOARD_H` is not written and sets `game_over`.
  - Writing onto an already-occupied cell overwrites it and sets `game_over`.
- **SCAN:** one row is examined per cycle.
  - If the row is full: at that edge, every row r in 1..pointer takes the contents of row r−1, and row 0 becomes empty. The count increments and the pointer does not change, so the same row is rescanned.
  - If the row is not full and the pointer is 0: go to DONE.
  - Otherwise: decrement the pointer.
- **DONE:** for one cycle, `clear_done`=1 and `rows_cleared`=count. Add the count to `lines_total` (saturating). Go to IDLE.
- **`busy`:** 1 in SCAN and DONE.
- **`lock` while `busy`:** ignored; sets `lock_dropped`.
- **`query_hit`:** 1 if any of the four query cells has x≥`BOARD_W` (this also catches decrement wrap to 31), has y≥`BOARD_H`, or lands on an occupied cell. It is forced to 1 while `busy`, which freezes the piece during clears.
- **Read port:** an out-of-range `x_coord`/`y_coord` returns occupied=0, colour=0. Reads reflect the board state after the most recent edge.
- **`Reset` mid-sequence:** abandons the sequence; the board is emptied and every output takes its reset value.

## Timing
- `lock` sampled at edge k: cells are visible on the read port after edge k, and `busy`=1 from edge k.
- With no full rows, SCAN takes `BOARD_H` cycles. DONE is then active during the cycle after edge k+20, and `busy` falls after edge k+21.
- Each cleared row adds exactly one cycle.
- `lock` arriving on the same cycle as DONE is dropped. `lock` arriving in the first IDLE cycle is accepted.
- `query_hit` and the read outputs have zero latency; they are purely combinational.

## Structure
- Shared package `tetris_pkg` holds `block_color`, `BOARD_W`/`BOARD_H` constants, and the `board_cell_t` struct (occupied, colour).
- Submodule `piece_collide`: combinational four-cell bounds-and-occupancy check. It is instantiated once for `query_hit`, and its bounds logic is reused for the lock-time `game_over` check.
- The board is a register array, not RAM, because the row shift updates all rows in a single cycle.

## Test plan
- **Single lock, no clear:** lock T-piece x={4,5,5,6}, y={1,0,1,1}, colour MAGENTA → cells (4,1),(5,0),(5,1),(6,1) read occupied/MAGENTA after one edge; `clear_done` 21 cycles later; `rows_cleared`=0.
- **Single-row clear:** prefill row 19 columns 0–5, then lock I-piece x={6,7,8,9}, y=19 → one clear, `rows_cleared`=1, `lines_total`=1; former row 18 contents appear in row 19; `busy` lasts 22 cycles.
- **Four-row clear:** fill rows 16–19 except column 9, then lock a vertical I-piece at x=9, y={16,17,18,19} → `rows_cleared`=4; board empty; 25 busy cycles.
- **Query:** query x={31,0,1,2} → `query_hit`=1; query y=20 → 1; query over an occupied cell → 1; query into free space → 0; any query while `busy` → 1.
- **Overlap and drop:** lock onto an occupied cell → `game_over`=1. A second `lock` during SCAN → `lock_dropped`=1 and the board is unchanged.
- **Reset mid-SCAN:** → board empty, `busy`=0, all counters 0 on the next cycle.
